// File: rtl/fp_align_sequencer.sv
// Exponent-alignment controller for the FP add path: orders two operands by magnitude and
// right-shifts the smaller mantissa by the exponent difference with guard/round/sticky capture.
module fp_align_sequencer #(
  parameter int MANT_W  = 24,
  parameter int EXP_W   = 8,
  parameter int SHAMT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 a_sign,
  input  logic                 b_sign,
  input  logic [EXP_W-1:0]     a_exp,
  input  logic [EXP_W-1:0]     b_exp,
  input  logic [MANT_W-1:0]    a_mant,
  input  logic [MANT_W-1:0]    b_mant,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W-1:0]     out_exp,
  output logic                 out_sign_big,
  output logic                 out_sign_small,
  output logic [MANT_W+2:0]    out_mant_big,
  output logic [MANT_W+2:0]    out_mant_small,
  output logic [SHAMT_W-1:0]   out_shamt,
  output logic                 out_swap
);

  localparam int EXT_W = MANT_W + 2;
  localparam logic [EXP_W-1:0]   SAT_DIFF  = EXP_W'(MANT_W + 3);
  localparam logic [SHAMT_W-1:0] SAT_SHAMT = SHAMT_W'(MANT_W + 3);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMP   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state_r;
  logic                 a_sign_r, b_sign_r;
  logic [EXP_W-1:0]     a_exp_r, b_exp_r;
  logic [MANT_W-1:0]    a_mant_r, b_mant_r;

  logic                 swap_r;
  logic [SHAMT_W-1:0]   shamt_r;
  logic                 big_sign_r, small_sign_r;
  logic [EXP_W-1:0]     big_exp_r;
  logic [MANT_W-1:0]    big_mant_r, small_mant_r;

  logic                 b_bigger_s;
  logic [EXP_W-1:0]     diff_s;
  logic [SHAMT_W-1:0]   shamt_cmp_s;
  logic [EXT_W-1:0]     ext_s;
  logic [EXT_W-1:0]     shifted_s;
  logic [EXT_W-1:0]     lost_mask_s;
  logic                 sticky_s;

  // Magnitude ordering and saturated shift amount from the captured operands.
  always_comb begin
    b_bigger_s  = 1'b0;
    diff_s      = {EXP_W{1'b0}};
    shamt_cmp_s = {SHAMT_W{1'b0}};
    if ((b_exp_r > a_exp_r) || ((b_exp_r == a_exp_r) && (b_mant_r > a_mant_r))) begin
      b_bigger_s = 1'b1;
      diff_s     = b_exp_r - a_exp_r;
    end else begin
      b_bigger_s = 1'b0;
      diff_s     = a_exp_r - b_exp_r;
    end
    if (diff_s >= SAT_DIFF) begin
      shamt_cmp_s = SAT_SHAMT;
    end else begin
      shamt_cmp_s = SHAMT_W'(diff_s);
    end
  end

  // Barrel shift of the small mantissa; a shift >= EXT_W clears the mask, so sticky covers all bits.
  always_comb begin
    ext_s       = {small_mant_r, 2'b00};
    shifted_s   = ext_s >> shamt_r;
    lost_mask_s = ~({EXT_W{1'b1}} << shamt_r);
    sticky_s    = |(ext_s & lost_mask_s);
  end

  // Sequencer FSM with all result fields and handshake outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      in_ready       <= 1'b1;
      out_valid      <= 1'b0;
      a_sign_r       <= 1'b0;
      b_sign_r       <= 1'b0;
      a_exp_r        <= {EXP_W{1'b0}};
      b_exp_r        <= {EXP_W{1'b0}};
      a_mant_r       <= {MANT_W{1'b0}};
      b_mant_r       <= {MANT_W{1'b0}};
      swap_r         <= 1'b0;
      shamt_r        <= {SHAMT_W{1'b0}};
      big_sign_r     <= 1'b0;
      small_sign_r   <= 1'b0;
      big_exp_r      <= {EXP_W{1'b0}};
      big_mant_r     <= {MANT_W{1'b0}};
      small_mant_r   <= {MANT_W{1'b0}};
      out_exp        <= {EXP_W{1'b0}};
      out_sign_big   <= 1'b0;
      out_sign_small <= 1'b0;
      out_mant_big   <= {(MANT_W+3){1'b0}};
      out_mant_small <= {(MANT_W+3){1'b0}};
      out_shamt      <= {SHAMT_W{1'b0}};
      out_swap       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_sign_r <= a_sign;
            b_sign_r <= b_sign;
            a_exp_r  <= a_exp;
            b_exp_r  <= b_exp;
            a_mant_r <= a_mant;
            b_mant_r <= b_mant;
            in_ready <= 1'b0;
            state_r  <= CMP;
          end else begin
            state_r  <= IDLE;
          end
        end
        CMP: begin
          swap_r  <= b_bigger_s;
          shamt_r <= shamt_cmp_s;
          if (b_bigger_s) begin
            big_sign_r   <= b_sign_r;
            small_sign_r <= a_sign_r;
            big_exp_r    <= b_exp_r;
            big_mant_r   <= b_mant_r;
            small_mant_r <= a_mant_r;
          end else begin
            big_sign_r   <= a_sign_r;
            small_sign_r <= b_sign_r;
            big_exp_r    <= a_exp_r;
            big_mant_r   <= a_mant_r;
            small_mant_r <= b_mant_r;
          end
          state_r <= SHIFT;
        end
        SHIFT: begin
          out_exp        <= big_exp_r;
          out_sign_big   <= big_sign_r;
          out_sign_small <= small_sign_r;
          out_mant_big   <= {big_mant_r, 3'b000};
          out_mant_small <= {shifted_s, sticky_s};
          out_shamt      <= shamt_r;
          out_swap       <= swap_r;
          out_valid      <= 1'b1;
          state_r        <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end else begin
            state_r   <= DONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_align_sequencer.sv
// Self-checking bench for fp_align_sequencer: directed cases plus randomized operand pairs,
// checked against an arithmetic reference model of the alignment rules.
module tb_fp_align_sequencer;

  localparam int MANT_W  = 24;
  localparam int EXP_W   = 8;
  localparam int SHAMT_W = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic                a_sign, b_sign;
  logic [EXP_W-1:0]    a_exp, b_exp;
  logic [MANT_W-1:0]   a_mant, b_mant;
  logic                out_valid;
  logic                out_ready;
  logic [EXP_W-1:0]    out_exp;
  logic                out_sign_big, out_sign_small;
  logic [MANT_W+2:0]   out_mant_big, out_mant_small;
  logic [SHAMT_W-1:0]  out_shamt;
  logic                out_swap;

  int n_cmp = 0;
  int n_bad = 0;

  // expected result fields from the model
  longint e_exp, e_sb, e_ss, e_big, e_small, e_shamt, e_swap;

  fp_align_sequencer #(.MANT_W(MANT_W), .EXP_W(EXP_W), .SHAMT_W(SHAMT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_sign(a_sign), .b_sign(b_sign),
    .a_exp(a_exp), .b_exp(b_exp),
    .a_mant(a_mant), .b_mant(b_mant),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_exp(out_exp),
    .out_sign_big(out_sign_big), .out_sign_small(out_sign_small),
    .out_mant_big(out_mant_big), .out_mant_small(out_mant_small),
    .out_shamt(out_shamt), .out_swap(out_swap)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Reference: order by (exp, mant) magnitude, then divide/remainder to get shifted part and sticky.
  task automatic model(input longint as_, input longint ae, input longint am,
                       input longint bs_, input longint be, input longint bm);
    longint sm, diff, ext, kept, pow;
    bit a_big;
    a_big = (ae > be) || ((ae == be) && (am >= bm));
    if (a_big) begin
      e_swap = 0; e_exp = ae; e_sb = as_; e_ss = bs_; e_big = am * 8; sm = bm; diff = ae - be;
    end else begin
      e_swap = 1; e_exp = be; e_sb = bs_; e_ss = as_; e_big = bm * 8; sm = am; diff = be - ae;
    end
    e_shamt = (diff >= MANT_W + 3) ? MANT_W + 3 : diff;
    ext  = sm * 4;
    pow  = longint'(1) << e_shamt;
    kept = ext / pow;
    e_small = kept * 2 + ((ext % pow) != 0 ? 1 : 0);
  endtask

  task automatic check_outs(input string tag);
    check_eq({tag, ".exp"},   64'(out_exp),        e_exp);
    check_eq({tag, ".sb"},    64'(out_sign_big),   e_sb);
    check_eq({tag, ".ss"},    64'(out_sign_small), e_ss);
    check_eq({tag, ".big"},   64'(out_mant_big),   e_big);
    check_eq({tag, ".small"}, 64'(out_mant_small), e_small);
    check_eq({tag, ".shamt"}, 64'(out_shamt),      e_shamt);
    check_eq({tag, ".swap"},  64'(out_swap),       e_swap);
  endtask

  task automatic scramble_inputs();
    a_sign = 1'($urandom); b_sign = 1'($urandom);
    a_exp  = 8'($urandom); b_exp  = 8'($urandom);
    a_mant = 24'($urandom); b_mant = 24'($urandom);
  endtask

  task automatic drive_op(input logic as_, input int ae, input int am,
                          input logic bs_, input int be, input int bm);
    @(negedge clk);
    check_eq("idle_ready", 64'(in_ready), 64'd1);
    a_sign = as_; a_exp = 8'(ae); a_mant = 24'(am);
    b_sign = bs_; b_exp = 8'(be); b_mant = 24'(bm);
    in_valid = 1'b1;
    model(64'(as_), longint'(ae), longint'(am), 64'(bs_), longint'(be), longint'(bm));
  endtask

  // Full transaction: accept, latency check, optional DONE stall with busy in_valid, handshake.
  task automatic run_op(input string tag, input logic as_, input int ae, input int am,
                        input logic bs_, input int be, input int bm,
                        input int stall, input logic busy_valid);
    drive_op(as_, ae, am, bs_, be, bm);
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = busy_valid;
    scramble_inputs();
    check_eq({tag, ".v_cmp"}, 64'(out_valid), 64'd0);
    check_eq({tag, ".r_cmp"}, 64'(in_ready), 64'd0);
    @(negedge clk);
    check_eq({tag, ".v_shift"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    check_eq({tag, ".v_done"}, 64'(out_valid), 64'd1);
    check_outs(tag);
    out_ready = (stall == 0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      scramble_inputs();
      check_eq({tag, ".v_hold"}, 64'(out_valid), 64'd1);
      check_eq({tag, ".r_hold"}, 64'(in_ready), 64'd0);
      check_outs({tag, ".hold"});
      if (s == stall - 1) out_ready = 1'b1;
    end
    @(negedge clk);
    check_eq({tag, ".v_after"}, 64'(out_valid), 64'd0);
    check_eq({tag, ".r_after"}, 64'(in_ready), 64'd1);
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin
    int ae, be, am, bm;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_sign = 1'b0; b_sign = 1'b0; a_exp = 8'd0; b_exp = 8'd0; a_mant = 24'd0; b_mant = 24'd0;
    repeat (3) @(negedge clk);
    check_eq("rst.valid", 64'(out_valid), 64'd0);
    check_eq("rst.ready", 64'(in_ready), 64'd1);
    check_eq("rst.small", 64'(out_mant_small), 64'd0);
    check_eq("rst.big", 64'(out_mant_big), 64'd0);
    rst = 1'b0;

    run_op("t1", 1'b0, 130, 'hC00000, 1'b0, 127, 'h800000, 0, 1'b0);
    check_eq("t1.small_lit", 64'(out_mant_small), 64'h0800000);
    run_op("t2", 1'b0, 100, 'h800001, 1'b1, 110, 'h800000, 1, 1'b0);
    check_eq("t2.small_lit", 64'(out_mant_small), 64'h0010001);
    run_op("t3", 1'b0, 200, 'hFFFFFF, 1'b0, 160, 'h800000, 2, 1'b1);
    check_eq("t3.shamt_lit", 64'(out_shamt), 64'd27);
    run_op("t4", 1'b0, 127, 'h900000, 1'b1, 127, 'hA00000, 0, 1'b0);
    check_eq("t4.small_lit", 64'(out_mant_small), 64'h4800000);
    run_op("t5", 1'b1, 140, 'h812345, 1'b0, 139, 'hFEDCBA, 5, 1'b1);
    run_op("tie", 1'b1, 90, 'hABCDEF, 1'b0, 90, 'hABCDEF, 0, 1'b0);
    run_op("d26", 1'b0, 126, 'hFFFFFF, 1'b0, 100, 'hFFFFFF, 0, 1'b0);

    // reset during SHIFT drops the operation
    drive_op(1'b0, 50, 'h8ABCDE, 1'b1, 45, 'hC00001);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("t6.valid", 64'(out_valid), 64'd0);
    check_eq("t6.ready", 64'(in_ready), 64'd1);
    check_eq("t6.small", 64'(out_mant_small), 64'd0);
    check_eq("t6.big", 64'(out_mant_big), 64'd0);
    check_eq("t6.exp", 64'(out_exp), 64'd0);
    check_eq("t6.shamt", 64'(out_shamt), 64'd0);
    run_op("t6.next", 1'b1, 60, 'hF00F0F, 1'b0, 64, 'h87654F, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      ae = int'($urandom_range(1, 254));
      be = ae + int'($urandom_range(0, 60)) - 30;
      if (be < 0) be = 0;
      if (be > 255) be = 255;
      am = int'($urandom & 32'h00FFFFFF) | 'h800000;
      bm = int'($urandom & 32'h00FFFFFF) | 'h800000;
      if ($urandom_range(0, 7) == 0) begin
        be = ae;
        if ($urandom_range(0, 1) == 1) bm = am;
      end
      run_op("rnd", 1'($urandom), ae, am, 1'($urandom), be, bm,
             int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
